// File: rtl/mult_share_ctrl.sv
// ============================================================================
// Module   : mult_share_ctrl
// Purpose  : Round-robin front end sharing one shift-add multiplier between
//            two valid/ready requesters, returning products per requester.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_share_ctrl #(
    parameter  int WIDTH = 3,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req_m0,
    input  logic [WIDTH-1:0]     req_M0,
    input  logic [WIDTH-1:0]     req_m1,
    input  logic [WIDTH-1:0]     req_M1,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_R,
    output logic                 busy,
    output logic [CW-1:0]        count_out
);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [WIDTH-1:0]    r_m;
    logic [2*WIDTH-1:0]  r_M;
    logic [2*WIDTH-1:0]  r_acc;
    logic [2*WIDTH-1:0]  r_rsp_R;
    logic [1:0]          r_rsp_valid;
    logic [CW-1:0]       r_count;
    logic                r_owner;
    logic                r_last_grant;

    logic                w_grant;
    logic [1:0]          w_req_ready;
    logic                w_accept;
    logic                w_rsp_hs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready is also gated by the active-low reset so nothing looks accepted
    // while the block is held in reset.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_req_ready  = 2'b00;
        w_accept     = 1'b0;
        w_rsp_hs     = 1'b0;

        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase

        case (r_state)
            c_IDLE: begin
                w_req_ready[w_grant] = req_valid[w_grant] & reset;
                w_accept             = |w_req_ready;
                if (w_accept) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                if (r_count == CW'(1)) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                w_rsp_hs = r_rsp_valid[r_owner] & rsp_ready[r_owner];
                if (w_rsp_hs) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m          <= '0;
            r_M          <= '0;
            r_acc        <= '0;
            r_rsp_R      <= '0;
            r_rsp_valid  <= 2'b00;
            r_count      <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_m          <= w_grant ? req_m1 : req_m0;
                        r_M          <= {{WIDTH{1'b0}}, (w_grant ? req_M1 : req_M0)};
                        r_acc        <= '0;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_count      <= CW'(WIDTH);
                    end
                end
                c_RUN: begin
                    if (r_m[0]) begin
                        r_acc <= r_acc + r_M;
                    end
                    r_m     <= r_m >> 1;
                    r_M     <= r_M << 1;
                    r_count <= r_count - CW'(1);
                end
                c_DONE: begin
                    // Result is presented one cycle after entering DONE and
                    // released only after the owner has seen it valid.
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 2'b00;
                    end else begin
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_rsp_R     <= r_acc;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_R     = r_rsp_R;
    assign busy      = (r_state != c_IDLE);
    assign count_out = r_count;

endmodule

`default_nettype wire
